ddr_axi_req_arbiter: RTL and testbench



---
 rtl/ddr_axi_req_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_ddr_axi_req_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_req_arbiter.sv
// Round-robin arbiter that turns PULP req/gnt/rvalid requests from several
// requesters into single-beat AXI4 reads and writes on one DDR master port.
// Only one transaction is in flight at a time.
module ddr_axi_req_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter logic [3:0]  AXI_ID     = 4'd0,
  parameter int unsigned RESET_LAST = NUM_REQ - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  // Requester side
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ-1:0]     we_i,
  input  logic [32*NUM_REQ-1:0]  addr_i,
  input  logic [32*NUM_REQ-1:0]  wdata_i,
  input  logic [4*NUM_REQ-1:0]   be_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
  // AXI write address channel
  output logic [31:0]            awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [3:0]             awid,
  output logic                   awvalid,
  input  logic                   awready,
  // AXI write data channel
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  // AXI write response channel
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready,
  // AXI read address channel
  output logic [31:0]            araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [3:0]             arid,
  output logic                   arvalid,
  input  logic                   arready,
  // AXI read data channel
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrReq  = 3'd1;
  localparam logic [2:0] StWrResp = 3'd2;
  localparam logic [2:0] StRdReq  = 3'd3;
  localparam logic [2:0] StRdData = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               req_found;
  logic [IdxW-1:0]    winner;
  logic               sel_we;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_be;

  // rlast is redundant with single-beat reads; only resp[1] is reported.
  logic unused_inputs;
  assign unused_inputs = ^{rlast, bresp[0], rresp[0]};

  // Round-robin search: first pending request above the last winner, with wrap.
  always_comb begin
    int unsigned cand;
    req_found = 1'b0;
    winner    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_q) + i) % NUM_REQ;
      if (!req_found && req_i[cand[IdxW-1:0]]) begin
        req_found = 1'b1;
        winner    = cand[IdxW-1:0];
      end
    end
  end

  // Select the winning requester's transaction fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == k[IdxW-1:0]) begin
        sel_we    = we_i[k];
        sel_addr  = addr_i[32*k +: 32];
        sel_wdata = wdata_i[32*k +: 32];
        sel_be    = be_i[4*k +: 4];
      end
    end
  end

  // Grants only leave IDLE; suppressed during reset so nobody sees a grant
  // that the captured registers will not honour.
  always_comb begin
    gnt_o = '0;
    if (!rst && (state_q == StIdle) && req_found) begin
      gnt_o[winner] = 1'b1;
    end
  end

  // Next-state logic for the transaction FSM and the registered outputs.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rvalid_d  = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      StIdle: begin
        if (req_found) begin
          last_d  = winner;
          idx_d   = winner;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          be_d    = sel_be;
          if (sel_we) begin
            state_d   = StWrReq;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StWrReq: begin
        // aw and w complete independently, in either order.
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (bvalid) begin
          rvalid_d[idx_q] = 1'b1;
          err_d           = bresp[1];
          state_d         = StIdle;
        end
      end
      StRdReq: begin
        if (arready) state_d = StRdData;
      end
      StRdData: begin
        if (rvalid) begin
          rvalid_d[idx_q] = 1'b1;
          rdata_d         = rdata;
          err_d           = rresp[1];
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= IdxW'(RESET_LAST);
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awid    = AXI_ID;
  assign awvalid = awvalid_q;

  assign wdata  = wdata_q;
  assign wstrb  = be_q;
  assign wlast  = 1'b1;
  assign wvalid = wvalid_q;

  assign bready = (state_q == StWrResp);

  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arid    = AXI_ID;
  assign arvalid = (state_q == StRdReq);

  assign rready = (state_q == StRdData);

endmodule

// File: tb/tb_ddr_axi_req_arbiter.sv
// Bench for ddr_axi_req_arbiter: directed requester traffic against a
// delay-programmable AXI slave, a transaction-level reference model compared
// every cycle, and hand-computed checks on the key scenarios.
module tb_ddr_axi_req_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam logic [3:0]  AXI_ID  = 4'h5;

  logic                  clk, rst;
  logic [NUM_REQ-1:0]    req_i, we_i, gnt_o, rvalid_o;
  logic [32*NUM_REQ-1:0] addr_i, wdata_i;
  logic [4*NUM_REQ-1:0]  be_i;
  logic [31:0]           rdata_o;
  logic                  err_o;
  logic [31:0]           awaddr, wdata, araddr, rdata;
  logic [7:0]            awlen, arlen;
  logic [2:0]            awsize, arsize;
  logic [1:0]            awburst, arburst, bresp, rresp;
  logic [3:0]            awid, arid, wstrb;
  logic                  awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic                  arvalid, arready, rlast, rvalid, rready;

  ddr_axi_req_arbiter #(.NUM_REQ(NUM_REQ), .AXI_ID(AXI_ID)) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AXI slave with per-channel ready/valid delays --------------
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int          aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  logic [31:0] s_rdata = 32'h0;
  logic [1:0]  s_rresp = 2'b00;
  logic [1:0]  s_bresp = 2'b00;

  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    bresp = 2'b00; rresp = 2'b00; rdata = 32'h0; rlast = 1'b1;
    forever begin
      @(posedge clk); #1;
      aw_c    = awvalid ? aw_c + 1 : 0;
      w_c     = wvalid  ? w_c + 1  : 0;
      b_c     = bready  ? b_c + 1  : 0;
      ar_c    = arvalid ? ar_c + 1 : 0;
      r_c     = rready  ? r_c + 1  : 0;
      awready = awvalid && (aw_c > aw_dly);
      wready  = wvalid  && (w_c > w_dly);
      bvalid  = bready  && (b_c > b_dly);
      arready = arvalid && (ar_c > ar_dly);
      rvalid  = rready  && (r_c > r_dly);
      bresp   = s_bresp;
      rresp   = s_rresp;
      rdata   = s_rdata;
    end
  end

  // ---------------- Transaction-level reference model --------------------------
  bit                 m_busy, m_we, m_aw, m_w, m_ar, m_err;
  int                 m_last, m_idx;
  logic [31:0]        m_addr, m_wdata, m_rdata;
  logic [3:0]         m_be;
  logic [NUM_REQ-1:0] m_pulse;

  initial begin : model
    logic [NUM_REQ-1:0] e_gnt;
    int                 win, k;
    bit                 e_aw, e_w, e_b, e_ar, e_r;
    m_busy = 0; m_we = 0; m_aw = 0; m_w = 0; m_ar = 0; m_err = 0;
    m_last = NUM_REQ - 1; m_idx = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0;
    m_pulse = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      // Who must be granted right now: first requester after the last winner.
      e_gnt = '0;
      win   = -1;
      if (!rst && !m_busy) begin
        for (int i = 1; i <= NUM_REQ; i++) begin
          k = (m_last + i) % NUM_REQ;
          if (win < 0 && req_i[k]) win = k;
        end
        if (win >= 0) e_gnt[win] = 1'b1;
      end
      e_aw = m_busy && m_we && m_aw;
      e_w  = m_busy && m_we && m_w;
      e_b  = m_busy && m_we && !m_aw && !m_w;
      e_ar = m_busy && !m_we && m_ar;
      e_r  = m_busy && !m_we && !m_ar;

      check("gnt_o", gnt_o, e_gnt);
      check("rvalid_o", rvalid_o, m_pulse);
      check("rdata_o", rdata_o, m_rdata);
      check("err_o", err_o, m_err);
      check("awvalid", awvalid, e_aw);
      check("wvalid", wvalid, e_w);
      check("bready", bready, e_b);
      check("arvalid", arvalid, e_ar);
      check("rready", rready, e_r);
      check("aw_const", {awlen, awsize, awburst, awid}, {8'd0, 3'b010, 2'b01, AXI_ID});
      check("ar_const", {arlen, arsize, arburst, arid}, {8'd0, 3'b010, 2'b01, AXI_ID});
      if (e_aw) check("awaddr", awaddr, m_addr);
      if (e_w) begin
        check("wdata", wdata, m_wdata);
        check("wstrb", wstrb, m_be);
        check("wlast", wlast, 1'b1);
      end
      if (e_ar) check("araddr", araddr, m_addr);

      // Advance the model across the coming clock edge.
      if (rst) begin
        m_busy = 0; m_aw = 0; m_w = 0; m_ar = 0; m_err = 0;
        m_last = NUM_REQ - 1; m_rdata = 0; m_pulse = '0;
      end else begin
        m_pulse = '0;
        if (m_busy && m_we) begin
          if (m_aw && awready) m_aw = 0;
          if (m_w && wready)   m_w  = 0;
          if (e_b && bvalid) begin
            m_pulse[m_idx] = 1'b1;
            m_err          = bresp[1];
            m_busy         = 0;
          end
        end else if (m_busy) begin
          if (m_ar) begin
            if (arready) m_ar = 0;
          end else if (rvalid) begin
            m_pulse[m_idx] = 1'b1;
            m_rdata        = rdata;
            m_err          = rresp[1];
            m_busy         = 0;
          end
        end else if (win >= 0) begin
          m_busy  = 1;
          m_idx   = win;
          m_last  = win;
          m_we    = we_i[win];
          m_addr  = addr_i[32*win +: 32];
          m_wdata = wdata_i[32*win +: 32];
          m_be    = be_i[4*win +: 4];
          m_aw    = m_we;
          m_w     = m_we;
          m_ar    = !m_we;
        end
      end
    end
  end

  // ---------------- Requester helpers -------------------------------------------
  task automatic set_req(input int k, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    req_i[k]          = 1'b1;
    we_i[k]           = we;
    addr_i[32*k +: 32] = a;
    wdata_i[32*k +: 32] = d;
    be_i[4*k +: 4]     = b;
  endtask

  task automatic wait_gnt(input int k);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (gnt_o[k]) break;
    end
  endtask

  task automatic wait_done(input string name, input int k);
    logic [NUM_REQ-1:0] oh;
    oh    = '0;
    oh[k] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rvalid_o[k]) break;
    end
    check(name, rvalid_o, oh);
  endtask

  // Raise a request, wait for its grant, drop it right after the grant edge.
  task automatic do_txn(input string name, input int k, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    logic [NUM_REQ-1:0] oh;
    oh    = '0;
    oh[k] = 1'b1;
    @(posedge clk); #1;
    set_req(k, we, a, d, b);
    wait_gnt(k);
    check(name, gnt_o, oh);
    @(posedge clk); #1;
    req_i[k] = 1'b0;
  endtask

  // ---------------- Directed scenarios -------------------------------------------
  int rr_exp[4] = '{0, 1, 0, 1};
  int who;

  initial begin
    rst = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_rvalid", rvalid_o, 2'b00);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, err_o}, 6'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read, zero-wait slave: grant T0, arvalid T1, rvalid_o T3.
    s_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    @(negedge clk);
    check("rd_gnt_t0", gnt_o, 2'b01);
    @(posedge clk); #1;
    req_i[0] = 1'b0;
    @(negedge clk);
    check("rd_arvalid_t1", arvalid, 1'b1);
    check("rd_araddr_t1", araddr, 32'h0000_1000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rd_rvalid_t3", rvalid_o, 2'b01);
    check("rd_rdata_t3", rdata_o, 32'hDEADBEEF);
    check("rd_err_t3", err_o, 1'b0);

    // Write with aw accepted at T1 and w held off until T5.
    w_dly = 4;
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'h40, 32'h12345678, 4'h3);
    @(negedge clk);
    check("wr_gnt_t0", gnt_o, 2'b10);
    @(posedge clk); #1;
    req_i[1] = 1'b0;
    @(negedge clk);
    check("wr_t1_valids", {awvalid, wvalid}, 2'b11);
    check("wr_t1_awaddr", awaddr, 32'h40);
    check("wr_t1_wstrb", wstrb, 4'h3);
    @(posedge clk);
    @(negedge clk);
    check("wr_t2_valids", {awvalid, wvalid}, 2'b01);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wr_t5_wvalid", wvalid, 1'b1);
    check("wr_t5_wdata", wdata, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    check("wr_t6_bready", {bready, wvalid}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    check("wr_t7_rvalid", rvalid_o, 2'b10);
    check("wr_t7_rdata_kept", rdata_o, 32'hDEADBEEF);
    w_dly = 0;

    // Round robin with both requesters held high for four reads.
    s_rdata = 32'h1111_0000;
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h200, 32'h0, 4'hF);
    for (int g = 0; g < 4; g++) begin
      who = -1;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (gnt_o != '0) begin
          who = gnt_o[1] ? 1 : 0;
          break;
        end
      end
      check("rr_order", who, rr_exp[g]);
      if (g == 3) begin
        @(posedge clk); #1;
        req_i = '0;
      end
    end
    wait_done("rr_last_done", 1);

    // Error responses: SLVERR read, then DECERR write.
    s_rdata = 32'hCAFEF00D;
    s_rresp = 2'b10;
    do_txn("er_rd_gnt", 0, 1'b0, 32'h2000, 32'h0, 4'hF);
    wait_done("er_rd_done", 0);
    check("er_rd_err", err_o, 1'b1);
    check("er_rd_rdata", rdata_o, 32'hCAFEF00D);
    s_rresp = 2'b00;
    s_bresp = 2'b11;
    do_txn("er_wr_gnt", 1, 1'b1, 32'h2004, 32'hA5A5A5A5, 4'hC);
    wait_done("er_wr_done", 1);
    check("er_wr_err", err_o, 1'b1);
    check("er_wr_rdata", rdata_o, 32'hCAFEF00D);
    s_bresp = 2'b00;

    // arready held low for ten cycles while req1 waits.
    ar_dly = 10;
    do_txn("bp_gnt0", 0, 1'b0, 32'h3000, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h4000, 32'h0, 4'hF);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_arvalid", arvalid, 1'b1);
      check("bp_araddr", araddr, 32'h3000);
      check("bp_no_gnt", gnt_o, 2'b00);
    end
    ar_dly = 0;
    wait_done("bp_done0", 0);
    // The completion cycle is IDLE and already grants the waiting requester.
    check("bp_gnt1", gnt_o, 2'b10);
    @(posedge clk); #1;
    req_i[1] = 1'b0;
    wait_done("bp_done1", 1);

    // Reset in the middle of a write with req0 pending.
    aw_dly = 20;
    w_dly  = 20;
    do_txn("rs_gnt1", 1, 1'b1, 32'h5000, 32'h55AA55AA, 4'hF);
    set_req(0, 1'b0, 32'h6000, 32'h0, 4'hF);
    @(negedge clk);
    check("rs_awvalid_before", awvalid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rs_gnt_in_rst", gnt_o, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check("rs_valids_after", {awvalid, wvalid}, 2'b00);
    check("rs_gnt_after", gnt_o, 2'b00);
    @(posedge clk); #1;
    rst    = 1'b0;
    aw_dly = 0;
    w_dly  = 0;
    @(negedge clk);
    check("rs_first_gnt", gnt_o, 2'b01);
    @(posedge clk); #1;
    req_i[0] = 1'b0;
    wait_done("rs_done0", 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
